// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO port: bus address width and register indices.
package gpio_pkg;

  localparam int AddrWidth = 3;

  localparam logic [AddrWidth-1:0] GPIO_IN      = 3'd0;
  localparam logic [AddrWidth-1:0] GPIO_OUT     = 3'd1;
  localparam logic [AddrWidth-1:0] GPIO_OUT_SET = 3'd2;
  localparam logic [AddrWidth-1:0] GPIO_OUT_CLR = 3'd3;
  localparam logic [AddrWidth-1:0] GPIO_RISE_EN = 3'd4;
  localparam logic [AddrWidth-1:0] GPIO_FALL_EN = 3'd5;
  localparam logic [AddrWidth-1:0] GPIO_STATUS  = 3'd6;

endpackage

// File: rtl/gpio_port_mm_if.sv
// Memory bus between the multicycle datapath (master) and the GPIO port (slave).
interface gpio_port_mm_if #(
  parameter int DataWidth = 32
) ();

  logic                           bus_valid;
  logic                           bus_we;
  logic [gpio_pkg::AddrWidth-1:0] bus_addr;
  logic [DataWidth-1:0]           bus_wdata;
  logic [DataWidth-1:0]           bus_rdata;
  logic                           bus_ready;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/gpio_debounce.sv
// One input pin: multi-flop synchroniser followed by a stability counter that
// only accepts a new level after DebounceCycles consecutive mismatching cycles.
module gpio_debounce #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  sync_out;

  assign sync_out = sync_q[SyncStages-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin};
      if (sync_out == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DebounceCycles - 1)) begin
        // mismatch has now lasted DebounceCycles cycles
        level <= sync_out;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_port_mm.sv
// Memory-mapped GPIO port: debounced inputs with edge capture and a level irq,
// output register with atomic set/clear, one-cycle-latency bus slave.
module gpio_port_mm
  import gpio_pkg::*;
#(
  parameter int DataWidth      = 32,
  parameter int NumPins        = 8,
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NumPins-1:0] GPIO_i,
  output logic [NumPins-1:0] GPIO_o,
  output logic               irq,
  gpio_port_mm_if.slave      bus
);

  logic [NumPins-1:0]   deb;
  logic [NumPins-1:0]   prev_q;
  logic [NumPins-1:0]   out_q;
  logic [NumPins-1:0]   rise_en_q;
  logic [NumPins-1:0]   fall_en_q;
  logic [NumPins-1:0]   status_q;
  logic [NumPins-1:0]   status_d;
  logic [NumPins-1:0]   edge_set;
  logic [NumPins-1:0]   w1c;
  logic [NumPins-1:0]   wpins;
  logic [NumPins-1:0]   rd_pins;
  logic [DataWidth-1:0] rdata_q;
  logic                 ready_q;
  logic                 wr;
  logic                 unused_wdata;

  for (genvar i = 0; i < NumPins; i++) begin : g_pin
    gpio_debounce #(
      .SyncStages    (SyncStages),
      .DebounceCycles(DebounceCycles)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .pin  (GPIO_i[i]),
      .level(deb[i])
    );
  end

  assign wr           = bus.bus_valid & bus.bus_we;
  assign wpins        = bus.bus_wdata[NumPins-1:0];
  assign unused_wdata = ^bus.bus_wdata;

  // edge set is ORed in after the clear so a same-cycle capture survives W1C
  assign edge_set = (deb & ~prev_q & rise_en_q) | (~deb & prev_q & fall_en_q);
  assign w1c      = (wr && bus.bus_addr == GPIO_STATUS) ? wpins : '0;
  assign status_d = (status_q & ~w1c) | edge_set;

  always_comb begin
    rd_pins = '0;
    case (bus.bus_addr)
      GPIO_IN:      rd_pins = deb;
      GPIO_OUT:     rd_pins = out_q;
      GPIO_RISE_EN: rd_pins = rise_en_q;
      GPIO_FALL_EN: rd_pins = fall_en_q;
      GPIO_STATUS:  rd_pins = status_q;
      default:      rd_pins = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      prev_q   <= deb;
      status_q <= status_d;
      ready_q  <= bus.bus_valid;
      if (bus.bus_valid) rdata_q <= DataWidth'(rd_pins);
      if (wr) begin
        case (bus.bus_addr)
          GPIO_OUT:     out_q     <= wpins;
          GPIO_OUT_SET: out_q     <= out_q | wpins;
          GPIO_OUT_CLR: out_q     <= out_q & ~wpins;
          GPIO_RISE_EN: rise_en_q <= wpins;
          GPIO_FALL_EN: fall_en_q <= wpins;
          default:      ;
        endcase
      end
    end
  end

  assign GPIO_o        = out_q;
  assign irq           = |status_q;
  assign bus.bus_rdata = rdata_q;
  assign bus.bus_ready = ready_q;

endmodule

// File: tb/tb_gpio_port_mm.sv
// Directed bench for gpio_port_mm: default 8-pin build plus a 16-pin build for output ops.
module tb_gpio_port_mm;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  gpio_i;
  logic [7:0]  gpio_o;
  logic        irq;
  logic [15:0] gpio_i16;
  logic [15:0] gpio_o16;
  logic        irq16;
  int          checks = 0;
  int          errors = 0;

  gpio_port_mm_if #(.DataWidth(32)) bus_if ();
  gpio_port_mm_if #(.DataWidth(32)) bus16_if ();

  gpio_port_mm #(.DataWidth(32), .NumPins(8), .SyncStages(2), .DebounceCycles(4)) dut (
    .clk(clk), .reset(reset), .GPIO_i(gpio_i), .GPIO_o(gpio_o), .irq(irq), .bus(bus_if)
  );

  gpio_port_mm #(.DataWidth(32), .NumPins(16), .SyncStages(2), .DebounceCycles(4)) dut16 (
    .clk(clk), .reset(reset), .GPIO_i(gpio_i16), .GPIO_o(gpio_o16), .irq(irq16), .bus(bus16_if)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
    tick();
    bus_if.bus_valid = 1'b0; bus_if.bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic rdy);
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a;
    tick();
    d = bus_if.bus_rdata; rdy = bus_if.bus_ready;
    bus_if.bus_valid = 1'b0;
  endtask

  task automatic bus16_write(input logic [2:0] a, input logic [31:0] d);
    bus16_if.bus_valid = 1'b1; bus16_if.bus_we = 1'b1; bus16_if.bus_addr = a; bus16_if.bus_wdata = d;
    tick();
    bus16_if.bus_valid = 1'b0; bus16_if.bus_we = 1'b0;
  endtask

  task automatic bus16_read(input logic [2:0] a, output logic [31:0] d);
    bus16_if.bus_valid = 1'b1; bus16_if.bus_we = 1'b0; bus16_if.bus_addr = a;
    tick();
    d = bus16_if.bus_rdata;
    bus16_if.bus_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic rdy;
    reset = 1'b1; gpio_i = '0; gpio_i16 = '0;
    bus_if.bus_valid = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    bus16_if.bus_valid = 1'b0; bus16_if.bus_we = 1'b0; bus16_if.bus_addr = '0; bus16_if.bus_wdata = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL reset_gpio_o: got %h expected 00", gpio_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (bus_if.bus_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus_if.bus_ready); end
    checks++; if (bus_if.bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_if.bus_rdata); end
    reset = 1'b0;
    bus_read(GPIO_IN, d, rdy);
    checks++; if (rdy !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reset_in: got rdy=%b %h expected rdy=1 0", rdy, d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d; logic rdy;
    gpio_i[0] = 1'b1;
    repeat (3) tick();
    gpio_i[0] = 1'b0;
    repeat (8) tick();
    bus_read(GPIO_IN, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL glitch_reject: got %h expected 0", d); end
    // continuous IN read; rdata after edge N+k reflects debounced before that edge
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = GPIO_IN;
    gpio_i[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) begin
        checks++; if (bus_if.bus_rdata !== 32'h0) begin errors++; $display("FAIL debounce_early: got %h expected 0", bus_if.bus_rdata); end
      end
      if (k == 6) begin
        checks++; if (bus_if.bus_rdata !== 32'h1) begin errors++; $display("FAIL debounce_accept: got %h expected 1", bus_if.bus_rdata); end
      end
    end
    bus_if.bus_valid = 1'b0;
  endtask

  task automatic test_out_ops();
    logic [31:0] d; logic rdy;
    bus_write(GPIO_OUT, 32'h0F);
    bus_write(GPIO_OUT_SET, 32'h30);
    bus_write(GPIO_OUT_CLR, 32'h03);
    checks++; if (gpio_o !== 8'h3C) begin errors++; $display("FAIL out_setclr: got %h expected 3c", gpio_o); end
    bus_read(GPIO_OUT, d, rdy);
    checks++; if (rdy !== 1'b1 || d !== 32'h3C) begin errors++; $display("FAIL out_read: got rdy=%b %h expected rdy=1 3c", rdy, d); end
    bus_read(GPIO_OUT_SET, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL out_set_read: got %h expected 0", d); end
    bus_read(GPIO_OUT_CLR, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL out_clr_read: got %h expected 0", d); end
    bus_write(GPIO_OUT, 32'hFFFF_FF00);
    checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL out_upper_ignored: got %h expected 00", gpio_o); end
  endtask

  task automatic test_edges();
    logic [31:0] d; logic rdy;
    gpio_i = 8'h02;
    repeat (8) tick();
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_disabled: got %h expected 0", d); end
    bus_write(GPIO_RISE_EN, 32'h01);
    bus_write(GPIO_FALL_EN, 32'h02);
    bus_read(GPIO_RISE_EN, d, rdy);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rise_en_read: got %h expected 1", d); end
    gpio_i[0] = 1'b1; repeat (8) tick();
    gpio_i[0] = 1'b0; repeat (8) tick();
    gpio_i[1] = 1'b0; repeat (8) tick();
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL edge_status: got %h expected 3", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b expected 1", irq); end
    bus_write(GPIO_STATUS, 32'h01);
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c: got %h expected 2", d); end
    gpio_i[1] = 1'b1; repeat (8) tick();
    // fall sampled at edge N -> debounced at N+5 -> STATUS set at N+6, same edge as the W1C
    gpio_i[1] = 1'b0; repeat (6) tick();
    bus_write(GPIO_STATUS, 32'h02);
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL set_wins: got %h expected 2", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic rdy;
    bus_write(GPIO_OUT, 32'h5A);
    bus_if.bus_valid = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = GPIO_OUT;
    tick();
    checks++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'h5A) begin errors++; $display("FAIL b2b_first: got rdy=%b %h expected rdy=1 5a", bus_if.bus_ready, bus_if.bus_rdata); end
    bus_if.bus_addr = GPIO_STATUS;
    tick();
    checks++; if (bus_if.bus_ready !== 1'b1 || bus_if.bus_rdata !== 32'h2) begin errors++; $display("FAIL b2b_second: got rdy=%b %h expected rdy=1 2", bus_if.bus_ready, bus_if.bus_rdata); end
    bus_if.bus_valid = 1'b0;
    tick();
    checks++; if (bus_if.bus_ready !== 1'b0 || bus_if.bus_rdata !== 32'h2) begin errors++; $display("FAIL b2b_hold: got rdy=%b %h expected rdy=0 2", bus_if.bus_ready, bus_if.bus_rdata); end
    bus_read(3'd7, d, rdy);
    checks++; if (rdy !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL reserved_read: got rdy=%b %h expected rdy=1 0", rdy, d); end
    bus_write(3'd7, 32'hFF);
    bus_read(GPIO_OUT, d, rdy);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL reserved_write: got %h expected 5a", d); end
  endtask

  task automatic test_wide();
    logic [31:0] d;
    bus16_write(GPIO_OUT, 32'h0F0F);
    bus16_write(GPIO_OUT_SET, 32'hF000);
    bus16_write(GPIO_OUT_CLR, 32'h0F00);
    checks++; if (gpio_o16 !== 16'hF00F) begin errors++; $display("FAIL wide_setclr: got %h expected f00f", gpio_o16); end
    bus16_read(GPIO_OUT, d);
    checks++; if (d !== 32'hF00F) begin errors++; $display("FAIL wide_read: got %h expected f00f", d); end
    bus16_read(GPIO_OUT_SET, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wide_set_read: got %h expected 0", d); end
    bus16_write(GPIO_OUT, 32'hFFFF_0000);
    checks++; if (gpio_o16 !== 16'h0000) begin errors++; $display("FAIL wide_upper_ignored: got %h expected 0000", gpio_o16); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d; logic rdy;
    gpio_i[0] = 1'b1; repeat (8) tick();
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL pre_reset_status: got %h expected 3", d); end
    bus_write(GPIO_OUT, 32'hA5);
    checks++; if (gpio_o !== 8'hA5) begin errors++; $display("FAIL pre_reset_out: got %h expected a5", gpio_o); end
    gpio_i = 8'h80;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    checks++; if (gpio_o !== 8'h00) begin errors++; $display("FAIL midrun_gpio_o: got %h expected 00", gpio_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrun_irq: got %b expected 0", irq); end
    checks++; if (bus_if.bus_rdata !== 32'h0) begin errors++; $display("FAIL midrun_rdata: got %h expected 0", bus_if.bus_rdata); end
    @(negedge clk);
    reset = 1'b0;
    bus_read(GPIO_IN, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_in: got %h expected 0", d); end
    bus_read(GPIO_STATUS, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_status: got %h expected 0", d); end
    bus_read(GPIO_RISE_EN, d, rdy);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrun_rise_en: got %h expected 0", d); end
    repeat (8) tick();
    bus_read(GPIO_IN, d, rdy);
    checks++; if (d !== 32'h80) begin errors++; $display("FAIL post_reset_in: got %h expected 80", d); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_out_ops();
    test_edges();
    test_back_to_back();
    test_wide();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
